// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the demux sequencer.
//   demux_state_t : sequencer FSM state (IDLE, SEND)
//   DEST_OUT1/2   : encoding of the per-word destination bit
//   DEF_*         : default widths/depths used by the top-level parameters
package demux_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } demux_state_t;

  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_W      = 16;

endpackage : demux_ctrl_pkg

// File: rtl/demux_ctrl_sync_fifo.sv
// Single-clock FIFO buffering {dest, data} entries ahead of the sequencer.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset (flushes pointers)
//   push     : write wdata when not full
//   pop      : advance read pointer when not empty
//   wdata    : entry to write
//   rdata    : head entry (valid while !empty)
//   full     : no free entries
//   empty    : no stored entries
// Pointers carry one extra wrap bit so full and empty are distinguished by
// comparing that MSB; they wrap naturally at 2*DEPTH.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Status flags from the registered pointers
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer and storage update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d                = wptr_q + PW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : sync_fifo

// File: rtl/demux_ctrl.sv
// Sequencer for the 1:2 data demux between the producer and two consumers.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    : producer handshake; in_ready = FIFO not full
//   in_data, in_dest     : word and destination (0 -> out1, 1 -> out2)
//   outN_valid/outN_ready: per-consumer handshake, N = 1, 2
//   outN_data            : per-consumer word, held when not selected
//   demux_sel            : destination of the word in flight
//   busy                 : FIFO not empty, or a word is in flight
//   cnt_out1/cnt_out2    : completed transfers per output, wrapping
module demux_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic [DATA_W-1:0] out2_data,
  output logic              demux_sel,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_out1,
  output logic [CNT_W-1:0]  cnt_out2
);

  localparam int unsigned EW = DATA_W + 1;

  demux_state_t      state_q, state_d;
  logic              out1_valid_q, out1_valid_d;
  logic              out2_valid_q, out2_valid_d;
  logic [DATA_W-1:0] out1_data_q, out1_data_d;
  logic [DATA_W-1:0] out2_data_q, out2_data_d;
  logic              demux_sel_q, demux_sel_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic [CNT_W-1:0]  cnt2_q, cnt2_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [EW-1:0]     fifo_wdata;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_dest;
  logic [DATA_W-1:0] head_data;
  logic              sel_ready;
  logic              load_next;

  // Input buffer; push is accepted purely on the full flag
  assign fifo_push  = in_valid & ~fifo_full;
  assign fifo_wdata = {in_dest, in_data};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_dest = fifo_rdata[DATA_W];
  assign head_data = fifo_rdata[DATA_W-1:0];

  // Ready of the selected consumer; only consulted in SEND, where its valid is 1
  assign sel_ready = (demux_sel_q == DEST_OUT2) ? out2_ready : out1_ready;

  // Next-state, pop and output register logic
  always_comb begin
    state_d      = state_q;
    out1_valid_d = out1_valid_q;
    out2_valid_d = out2_valid_q;
    out1_data_d  = out1_data_q;
    out2_data_d  = out2_data_q;
    demux_sel_d  = demux_sel_q;
    cnt1_d       = cnt1_q;
    cnt2_d       = cnt2_q;
    fifo_pop     = 1'b0;
    load_next    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load_next = 1'b1;
        end
      end
      SEND: begin
        if (sel_ready) begin
          if (demux_sel_q == DEST_OUT2) begin
            cnt2_d = cnt2_q + CNT_W'(1);
          end else begin
            cnt1_d = cnt1_q + CNT_W'(1);
          end
          if (!fifo_empty) begin
            load_next = 1'b1;
          end else begin
            out1_valid_d = 1'b0;
            out2_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
    endcase

    // Pop the head and present it on its output; the other output keeps its data
    if (load_next) begin
      fifo_pop    = 1'b1;
      state_d     = SEND;
      demux_sel_d = head_dest;
      if (head_dest == DEST_OUT2) begin
        out2_data_d  = head_data;
        out2_valid_d = 1'b1;
        out1_valid_d = 1'b0;
      end else begin
        out1_data_d  = head_data;
        out1_valid_d = 1'b1;
        out2_valid_d = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out1_valid_q <= 1'b0;
      out2_valid_q <= 1'b0;
      out1_data_q  <= '0;
      out2_data_q  <= '0;
      demux_sel_q  <= DEST_OUT1;
      cnt1_q       <= '0;
      cnt2_q       <= '0;
    end else begin
      state_q      <= state_d;
      out1_valid_q <= out1_valid_d;
      out2_valid_q <= out2_valid_d;
      out1_data_q  <= out1_data_d;
      out2_data_q  <= out2_data_d;
      demux_sel_q  <= demux_sel_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
    end
  end

  assign in_ready   = ~fifo_full;
  assign busy       = ~fifo_empty | (state_q == SEND);
  assign out1_valid = out1_valid_q;
  assign out2_valid = out2_valid_q;
  assign out1_data  = out1_data_q;
  assign out2_data  = out2_data_q;
  assign demux_sel  = demux_sel_q;
  assign cnt_out1   = cnt1_q;
  assign cnt_out2   = cnt2_q;

endmodule : demux_ctrl

// File: tb/tb_demux_ctrl.sv
// Scoreboard bench for demux_ctrl: expected {dest, data} pushed when a word is
// accepted, compared in order against handshakes captured by the monitor.
module tb_demux_ctrl;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_dest;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out2_valid;
  logic              out2_ready;
  logic [DATA_W-1:0] out2_data;
  logic              demux_sel;
  logic              busy;
  logic [CNT_W-1:0]  cnt_out1;
  logic [CNT_W-1:0]  cnt_out2;

  int          nvec = 0;
  int          nerr = 0;
  logic [32:0] exp_q[$];
  logic [33:0] obs_q[$];
  int          obs_rd = 0;
  bit          both_seen = 1'b0;

  demux_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data),
    .demux_sel  (demux_sel),
    .busy       (busy),
    .cnt_out1   (cnt_out1),
    .cnt_out2   (cnt_out2)
  );

  always #5 clk = ~clk;

  // Capture completed handshakes as {sel, output index, data}
  always @(negedge clk) begin
    if (!rst) begin
      if (out1_valid && out2_valid) both_seen = 1'b1;
      if (out1_valid && out1_ready) obs_q.push_back({demux_sel, 1'b0, out1_data});
      if (out2_valid && out2_ready) obs_q.push_back({demux_sel, 1'b1, out2_data});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  // Offer one word until accepted (bounded); records the expectation on acceptance
  task automatic push_word(input logic [31:0] d, input logic dst, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_dest = dst;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back({dst, d});
      end
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hA5A5_5A5A;
    in_dest = 1'b1;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    repeat (3) cyc();
    nvec++;
    if ({out1_valid, out2_valid, demux_sel} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_valids: got %b, required 000", {out1_valid, out2_valid, demux_sel});
    end
    nvec++;
    if ({cnt_out1, cnt_out2, out1_data, out2_data} !== '0) begin
      nerr++;
      $display("FAIL reset_regs: got cnt1=%0d cnt2=%0d d1=%h d2=%h, required all 0",
               cnt_out1, cnt_out2, out1_data, out2_data);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cyc();
    nvec++;
    if ({in_ready, busy, out1_valid, out2_valid} !== 4'b1000) begin
      nerr++;
      $display("FAIL reset_release: got ready/busy/v1/v2=%b, required 1000",
               {in_ready, busy, out1_valid, out2_valid});
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic test_single();
    bit ok;
    logic [32:0] e;
    logic [33:0] o;
    do_reset();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    push_word(32'hDEADBEEF, 1'b1, ok);
    nvec++;
    if (ok !== 1'b1 || out2_valid !== 1'b0) begin
      nerr++;
      $display("FAIL single_push: got accepted=%b v2=%b, required accepted=1 v2=0", ok, out2_valid);
    end
    cyc();
    nvec++;
    if ({out1_valid, out2_valid, demux_sel, out2_data} !== {3'b011, 32'hDEADBEEF}) begin
      nerr++;
      $display("FAIL single_out: got v1=%b v2=%b sel=%b d2=%h, required 0 1 1 deadbeef",
               out1_valid, out2_valid, demux_sel, out2_data);
    end
    cyc();
    nvec++;
    if ({cnt_out1, cnt_out2, out2_valid, busy} !== {4'd0, 4'd1, 2'b00}) begin
      nerr++;
      $display("FAIL single_done: got cnt1=%0d cnt2=%0d v2=%b busy=%b, required 0 1 0 0",
               cnt_out1, cnt_out2, out2_valid, busy);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nvec++;
      if (obs_rd >= obs_q.size()) begin
        nerr++;
        $display("FAIL sb_single: got no output, required %h", e);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if (o !== {e[32], e}) begin
          nerr++;
          $display("FAIL sb_single: got %h, required %h", o, {e[32], e});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    logic [32:0] e;
    logic [33:0] o;
    logic        s;
    do_reset();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 4; i++) w[i] = 32'h1000_0000 + 32'(i * 17) + $urandom_range(0, 255) * 32'h100;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = w[i];
      in_dest = 1'(i);
      exp_q.push_back({1'(i), w[i]});
      cyc();
      if (i >= 1) begin
        s = 1'(i - 1);
        nvec++;
        if ({out2_valid, out1_valid, demux_sel} !== {s, ~s, s}) begin
          nerr++;
          $display("FAIL b2b_cycle%0d: got v2v1sel=%b, required %b", i, {out2_valid, out1_valid, demux_sel}, {s, ~s, s});
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    nvec++;
    if ({out2_valid, out1_valid, demux_sel} !== 3'b101) begin
      nerr++;
      $display("FAIL b2b_cycle4: got v2v1sel=%b, required 101", {out2_valid, out1_valid, demux_sel});
    end
    cyc();
    nvec++;
    if ({cnt_out1, cnt_out2, out1_valid, out2_valid, busy} !== {4'd2, 4'd2, 3'b000}) begin
      nerr++;
      $display("FAIL b2b_counts: got cnt1=%0d cnt2=%0d v=%b%b busy=%b, required 2 2 00 0",
               cnt_out1, cnt_out2, out1_valid, out2_valid, busy);
    end
    nvec++;
    if ({out1_data, out2_data} !== {w[2], w[3]}) begin
      nerr++;
      $display("FAIL b2b_hold: got d1=%h d2=%h, required %h %h", out1_data, out2_data, w[2], w[3]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nvec++;
      if (obs_rd >= obs_q.size()) begin
        nerr++;
        $display("FAIL sb_b2b: got no output, required %h", e);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if (o !== {e[32], e}) begin
          nerr++;
          $display("FAIL sb_b2b: got %h, required %h", o, {e[32], e});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit all_ok;
    bit held;
    logic [31:0] w0;
    logic [32:0] e;
    logic [33:0] o;
    do_reset();
    out1_ready = 1'b0;
    out2_ready = 1'b1;
    all_ok = 1'b1;
    w0 = 32'hC0DE_0000;
    for (int i = 0; i < 5; i++) begin
      push_word(w0 + 32'(i), 1'b0, ok);
      all_ok &= ok;
    end
    nvec++;
    if ({all_ok, in_ready, out1_valid, out1_data} !== {3'b101, w0}) begin
      nerr++;
      $display("FAIL bp_full: got acc=%b ready=%b v1=%b d1=%h, required 1 0 1 %h",
               all_ok, in_ready, out1_valid, out1_data, w0);
    end
    // Extra offer while full must be refused and the head must stay put
    held = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hBAD0_BAD0;
    in_dest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (in_ready !== 1'b0 || out1_valid !== 1'b1 || out1_data !== w0 || out2_valid !== 1'b0) held = 1'b0;
    end
    in_valid = 1'b0;
    nvec++;
    if (held !== 1'b1) begin
      nerr++;
      $display("FAIL bp_hold: got held=%b, required 1", held);
    end
    out1_ready = 1'b1;
    for (int i = 0; i < 40 && busy; i++) cyc();
    nvec++;
    if ({busy, cnt_out1, cnt_out2} !== {1'b0, 4'd5, 4'd0}) begin
      nerr++;
      $display("FAIL bp_drain: got busy=%b cnt1=%0d cnt2=%0d, required 0 5 0", busy, cnt_out1, cnt_out2);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nvec++;
      if (obs_rd >= obs_q.size()) begin
        nerr++;
        $display("FAIL sb_bp: got no output, required %h", e);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if (o !== {e[32], e}) begin
          nerr++;
          $display("FAIL sb_bp: got %h, required %h", o, {e[32], e});
        end
      end
    end
    nvec++;
    if (obs_rd !== obs_q.size()) begin
      nerr++;
      $display("FAIL sb_bp_extra: got %0d outputs, required %0d", obs_q.size(), obs_rd);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit quiet;
    int seen;
    do_reset();
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h7700_0000 + 32'(i), 1'b0, ok);
    nvec++;
    if ({out1_valid, busy, out1_data} !== {2'b11, 32'h7700_0000}) begin
      nerr++;
      $display("FAIL mid_pre: got v1=%b busy=%b d1=%h, required 1 1 77000000", out1_valid, busy, out1_data);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    nvec++;
    if ({out1_valid, out2_valid, busy, in_ready, out1_data} !== {4'b0001, 32'h0}) begin
      nerr++;
      $display("FAIL mid_reset: got v1=%b v2=%b busy=%b ready=%b d1=%h, required 0 0 0 1 0",
               out1_valid, out2_valid, busy, in_ready, out1_data);
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    seen = obs_q.size();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    nvec++;
    if (quiet !== 1'b1 || obs_q.size() !== seen) begin
      nerr++;
      $display("FAIL mid_quiet: got quiet=%b outputs=%0d, required 1 %0d", quiet, obs_q.size(), seen);
    end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    bit all_ok;
    logic [32:0] e;
    logic [33:0] o;
    do_reset();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_word($urandom, 1'b0, ok);
      all_ok &= ok;
    end
    for (int i = 0; i < 40 && busy; i++) cyc();
    nvec++;
    if ({all_ok, busy, cnt_out1, cnt_out2} !== {2'b10, 4'd1, 4'd0}) begin
      nerr++;
      $display("FAIL wrap_cnt: got acc=%b busy=%b cnt1=%0d cnt2=%0d, required 1 0 1 0",
               all_ok, busy, cnt_out1, cnt_out2);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nvec++;
      if (obs_rd >= obs_q.size()) begin
        nerr++;
        $display("FAIL sb_wrap: got no output, required %h", e);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if (o !== {e[32], e}) begin
          nerr++;
          $display("FAIL sb_wrap: got %h, required %h", o, {e[32], e});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_dest = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    nvec++;
    if (both_seen !== 1'b0) begin
      nerr++;
      $display("FAIL both_valid: got both valids high at some cycle, required never");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required finish");
    $fatal(1);
  end

endmodule : tb_demux_ctrl
